// File: rtl/pooling_layer_v2.sv
// Streaming STRIDE x STRIDE max/average pooling over a raster-order multi-channel frame.
// Optional macro POOL_ROUND_EN: average mode rounds half-up instead of truncating.
module pooling_layer_v2 #(
  parameter int I_WIDTH      = 8,
  parameter int CHANNELS     = 3,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 32,
  parameter int STRIDE       = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic                          input_valid,
  input  logic                          pool_mode,
  input  logic [CHANNELS*I_WIDTH-1:0]   input_data,
  output logic [CHANNELS*I_WIDTH-1:0]   output_data,
  output logic                          valid,
  output logic                          frame_done
);

  localparam int LOG_S = $clog2(STRIDE);
  localparam int A_W   = I_WIDTH + 2*LOG_S;
  localparam int NWX   = IMAGE_WIDTH / STRIDE;
  localparam int NWY   = IMAGE_HEIGHT / STRIDE;
  localparam int XW    = (IMAGE_WIDTH > 1)  ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int YW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int WXW   = (NWX > 1) ? $clog2(NWX) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                        state_q, state_d;
  logic                          mode_q, mode_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [YW-1:0]                 y_q, y_d;
  logic                          valid_q, valid_d;
  logic                          frame_done_q, frame_done_d;
  logic [CHANNELS*I_WIDTH-1:0]   output_data_q, output_data_d;
  logic [A_W-1:0]                acc_q [NWX][CHANNELS];
  logic [A_W-1:0]                acc_d [NWX][CHANNELS];

  logic                          accept, last_x, last_y, in_region;
  logic                          first_win, last_win, eff_mode;
  logic [WXW-1:0]                wx;
  logic [CHANNELS-1:0][A_W-1:0]  comb;
  logic [CHANNELS*I_WIDTH-1:0]   pooled;

  assign accept    = clk_en && input_valid;
  assign last_x    = (int'(x_q) == IMAGE_WIDTH-1);
  assign last_y    = (int'(y_q) == IMAGE_HEIGHT-1);
  // Trailing partial windows are counted through but never touch the buffer.
  assign in_region = (int'(x_q) < NWX*STRIDE) && (int'(y_q) < NWY*STRIDE);
  assign wx        = in_region ? WXW'(x_q >> LOG_S) : '0;
  assign first_win = (y_q[LOG_S-1:0] == '0) && (x_q[LOG_S-1:0] == '0);
  assign last_win  = (&y_q[LOG_S-1:0]) && (&x_q[LOG_S-1:0]);
  // The first pixel of a frame uses the live mode; later pixels use the latched one.
  assign eff_mode  = (state_q == IDLE) ? pool_mode : mode_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [A_W-1:0] samp, prev, avg_sum;
    assign samp    = A_W'(input_data[g*I_WIDTH +: I_WIDTH]);
    assign prev    = acc_q[wx][g];
    assign comb[g] = first_win ? samp :
                     eff_mode  ? prev + samp :
                     (samp > prev) ? samp : prev;
`ifdef POOL_ROUND_EN
    assign avg_sum = comb[g] + A_W'(2**(2*LOG_S-1));
`else
    assign avg_sum = comb[g];
`endif
    assign pooled[g*I_WIDTH +: I_WIDTH] = eff_mode ? I_WIDTH'(avg_sum >> (2*LOG_S))
                                                   : comb[g][I_WIDTH-1:0];
  end

  always_comb begin
    acc_d = acc_q;
    if (accept && in_region) begin
      for (int ch = 0; ch < CHANNELS; ch++) acc_d[wx][ch] = comb[ch];
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    x_d           = x_q;
    y_d           = y_q;
    valid_d       = 1'b0;
    frame_done_d  = 1'b0;
    output_data_d = output_data_q;
    if (accept) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (state_q == IDLE) begin
        mode_d  = pool_mode;
        state_d = ACTIVE;
      end
      if (last_x && last_y) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end
      if (in_region && last_win) begin
        valid_d       = 1'b1;
        output_data_d = pooled;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      output_data_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      x_q           <= x_d;
      y_q           <= y_d;
      valid_q       <= valid_d;
      frame_done_q  <= frame_done_d;
      output_data_q <= output_data_d;
    end
  end

  // Window buffer needs no reset: a window's first pixel always overwrites its entry.
  always_ff @(posedge clk) acc_q <= acc_d;

  assign output_data = output_data_q;
  assign valid       = valid_q;
  assign frame_done  = frame_done_q;

endmodule
